hazard_scoreboard: RTL

//  Parametrised RAW-hazard scoreboard for the N-stage in-order pipeline. Replaces the fixed

---
 rtl/hazard_scoreboard_pkg.sv | 26 ++
 rtl/hazard_scoreboard_if.sv | 46 ++++
 rtl/hazard_scoreboard_sb_match.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 100 ++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_pkg
// Purpose  : Shared constants and helpers for the RAW-hazard scoreboard:
//            forward-select encoding and select-width computation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

  // Forward-select code meaning "take the operand from the register file".
  // A nonzero code k selects the result held in slot k-1.
  localparam int FWD_RF = 0;

  // Slot index constants for the default 3-deep in-order pipe.
  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;

  // Width needed to encode FWD_RF plus one code per tracked slot.
  function automatic int sel_width(input int nslot);
    return $clog2(nslot + 1);
  endfunction

endpackage : hazard_scoreboard_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_if
// Purpose  : Bundles the ID-stage issue/source-operand signals and the
//            scoreboard's stall/forward/debug outputs.
// Modports : master - ID stage / pipeline control (drives issue, sources, flush)
//            slave  - scoreboard (drives stall, fwd_sel, slot_valid, stall_cnt)
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int NSLOT = 3,
  parameter int NRD   = 2,
  parameter int CNTW  = 16
) ();

  localparam int AW = $clog2(NREG);
  localparam int SW = sel_width(NSLOT);

  logic                iss_valid;
  logic                iss_regwrite;
  logic                iss_is_load;
  logic [AW-1:0]       iss_wreg;
  logic [NRD*AW-1:0]   src_reg;
  logic [NRD-1:0]      src_used;
  logic                flush;

  logic                stall;
  logic [NRD*SW-1:0]   fwd_sel;
  logic [NSLOT-1:0]    slot_valid;
  logic [CNTW-1:0]     stall_cnt;

  modport master (
    output iss_valid, iss_regwrite, iss_is_load, iss_wreg, src_reg, src_used, flush,
    input  stall, fwd_sel, slot_valid, stall_cnt
  );

  modport slave (
    input  iss_valid, iss_regwrite, iss_is_load, iss_wreg, src_reg, src_used, flush,
    output stall, fwd_sel, slot_valid, stall_cnt
  );

endinterface : hazard_scoreboard_if
`default_nettype wire

// File: rtl/hazard_scoreboard_sb_match.sv
`default_nettype none
// ============================================================================
// Module   : sb_match
// Purpose  : Per-read-port matcher. Finds the youngest valid in-flight slot
//            writing the requested source register and reports its forward
//            code, plus a load-use hazard when that data is not ready yet.
// Ports    : i_slot_valid/i_slot_wreg/i_slot_load - packed slot state
//            i_src_reg/i_src_used                   - this port's operand
//            o_fwd_sel                              - 0=RF, k+1=slot k
//            o_hazard                               - load-use on this port
// Revision : 1.0 - initial release
// ============================================================================
module sb_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int NSLOT    = 3,
  parameter int AW       = 5,
  parameter int SW       = 2,
  parameter int LOAD_RDY = 1
) (
  input  wire logic [NSLOT-1:0]    i_slot_valid,
  input  wire logic [NSLOT*AW-1:0] i_slot_wreg,
  input  wire logic [NSLOT-1:0]    i_slot_load,
  input  wire logic [AW-1:0]       i_src_reg,
  input  wire logic                i_src_used,
  output logic      [SW-1:0]       o_fwd_sel,
  output logic                     o_hazard
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    o_fwd_sel = SW'(FWD_RF);
    o_hazard  = 1'b0;
    for (int k = NSLOT - 1; k >= 0; k--) begin
      if (i_slot_valid[k] && i_src_used && (i_src_reg != '0) &&
          (i_slot_wreg[k*AW +: AW] == i_src_reg)) begin
        o_fwd_sel = SW'(k + 1);
        o_hazard  = (k < LOAD_RDY) && i_slot_load[k];
      end
    end
  end

endmodule : sb_match
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : RAW-hazard scoreboard for an in-order pipeline. Tracks in-flight
//            destination registers from EX to WB, selects forwarding sources
//            for each ID source operand, raises load-use stalls, applies
//            branch/jump flush and counts stall cycles (saturating).
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-high reset
//            bus  - hazard_scoreboard_if.slave (issue, sources, flush in;
//                   stall, fwd_sel, slot_valid, stall_cnt out)
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG        = 32,
  parameter int NSLOT       = 3,
  parameter int NRD         = 2,
  parameter int LOAD_RDY    = 1,
  parameter int FLUSH_SLOTS = 1,
  parameter int CNTW        = 16
) (
  input wire logic            clk,
  input wire logic            rst,
  hazard_scoreboard_if.slave  bus
);

  localparam int AW = $clog2(NREG);
  localparam int SW = sel_width(NSLOT);

  // Slot 0 = EX (youngest) ... slot NSLOT-1 = WB (oldest).
  logic [NSLOT-1:0]    r_slot_valid;
  logic [NSLOT*AW-1:0] r_slot_wreg;
  logic [NSLOT-1:0]    r_slot_load;
  logic [CNTW-1:0]     r_stall_cnt;

  logic [NRD*SW-1:0]   w_fwd_sel;
  logic [NRD-1:0]      w_hazard;
  logic                w_stall;
  logic                w_issue_valid;
  logic [NSLOT-1:0]    w_next_valid;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    sb_match #(
      .NSLOT    (NSLOT),
      .AW       (AW),
      .SW       (SW),
      .LOAD_RDY (LOAD_RDY)
    ) u_match (
      .i_slot_valid (r_slot_valid),
      .i_slot_wreg  (r_slot_wreg),
      .i_slot_load  (r_slot_load),
      .i_src_reg    (bus.src_reg[p*AW +: AW]),
      .i_src_used   (bus.src_used[p]),
      .o_fwd_sel    (w_fwd_sel[p*SW +: SW]),
      .o_hazard     (w_hazard[p])
    );
  end : g_port

  // Flush wins over stall: a killed issue never holds the front end.
  assign w_stall = bus.iss_valid & ~bus.flush & (|w_hazard);

  // Register 0 writes are never tracked, so they can never cause a hazard.
  assign w_issue_valid = bus.iss_valid & bus.iss_regwrite & ~w_stall & ~bus.flush &
                         (bus.iss_wreg != '0);

  // Shifted valid vector with the youngest FLUSH_SLOTS entries killed on flush.
  always_comb begin
    w_next_valid = {r_slot_valid[NSLOT-2:0], w_issue_valid};
    for (int i = 0; i < NSLOT; i++) begin
      if (bus.flush && (i < FLUSH_SLOTS)) begin
        w_next_valid[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_valid <= '0;
      r_slot_wreg  <= '0;
      r_slot_load  <= '0;
      r_stall_cnt  <= '0;
    end else begin
      r_slot_valid <= w_next_valid;
      r_slot_wreg  <= {r_slot_wreg[(NSLOT-1)*AW-1:0], bus.iss_wreg};
      r_slot_load  <= {r_slot_load[NSLOT-2:0], bus.iss_is_load};
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign bus.stall      = w_stall;
  assign bus.fwd_sel    = w_fwd_sel;
  assign bus.slot_valid = r_slot_valid;
  assign bus.stall_cnt  = r_stall_cnt;

endmodule : hazard_scoreboard
`default_nettype wire
